// File: rtl/cu_command_arbiter_rr.sv
// Per-requester command FIFOs feeding a single CU command buffer.
// Each requester gets its own FIFO. The FIFOs are drained round-robin,
// one command per cycle, under downstream almost-full back-pressure.

package cu_arb_pkg;

  typedef struct packed {
    logic [7:0] command;
    logic [7:0] cu_id_x;
    logic [7:0] cu_id_y;
  } CommandBufferCmd;

  typedef struct packed {
    logic            valid;
    logic [31:0]     address;
    CommandBufferCmd cmd;
  } CommandBufferLine;

  typedef struct packed {
    logic empty;
    logic alfull;
    logic full;
  } BufferStatus;

endpackage

module cu_command_arbiter_rr
  import cu_arb_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int FIFO_DEPTH    = 16,
  parameter int ALFULL_MARGIN = 4
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  enabled_in,
  input  CommandBufferLine      command_in [NUM_REQ],
  input  BufferStatus           command_buffer_status_in,
  output BufferStatus           command_buffer_status_out [NUM_REQ],
  output CommandBufferLine      command_out,
  output logic [NUM_REQ-1:0]    grant_out,
  output logic [NUM_REQ-1:0]    overflow_error_out
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(NUM_REQ);
  localparam logic [CW-1:0] FULL_CNT   = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] ALFULL_CNT = CW'(FIFO_DEPTH - ALFULL_MARGIN);

  CommandBufferLine   fifo_mem [NUM_REQ][FIFO_DEPTH];
  logic [AW-1:0]      rd_ptr   [NUM_REQ];
  logic [AW-1:0]      wr_ptr   [NUM_REQ];
  logic [CW-1:0]      count    [NUM_REQ];
  logic [PW-1:0]      rr_ptr;
  logic [PW-1:0]      win_idx;
  logic               win_found;
  logic               arb_go;
  logic [NUM_REQ-1:0] pop;
  logic [NUM_REQ-1:0] push_ok;

  // Only alfull of the downstream status matters; the rest is deliberately ignored.
  logic unused_status_bits;
  assign unused_status_bits = command_buffer_status_in.empty ^ command_buffer_status_in.full;

  // Round-robin search. Iterating from the farthest offset back to the nearest
  // lets the nearest non-empty FIFO after rr_ptr win without needing a break.
  always_comb begin
    win_found = 1'b0;
    win_idx   = rr_ptr;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (count[PW'((int'(rr_ptr) + k) % NUM_REQ)] != '0) begin
        win_found = 1'b1;
        win_idx   = PW'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  assign arb_go = enabled_in && !command_buffer_status_in.alfull && win_found;

  // Pop the winner. A push is accepted if the FIFO has room once this cycle's pop is counted.
  always_comb begin
    pop     = '0;
    push_ok = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pop[i]     = arb_go && (win_idx == PW'(i));
      push_ok[i] = command_in[i].valid && ((count[i] != FULL_CNT) || pop[i]);
    end
  end

  // FIFO storage. It is not reset: the counts alone define which entries are live.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (push_ok[i]) fifo_mem[i][wr_ptr[i]] <= command_in[i];
    end
  end

  // Per-FIFO pointers, occupancy and the sticky drop flags.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
      overflow_error_out <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (push_ok[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
        if (pop[i])     rd_ptr[i] <= rd_ptr[i] + AW'(1);
        count[i] <= count[i] + {{AW{1'b0}}, push_ok[i]} - {{AW{1'b0}}, pop[i]};
        if (command_in[i].valid && !push_ok[i]) overflow_error_out[i] <= 1'b1;
      end
    end
  end

  // Register the popped head entry together with its one-hot grant.
  // On a stall the payload is left stale and only valid and grant are cleared.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      command_out <= '0;
      grant_out   <= '0;
      rr_ptr      <= PW'(NUM_REQ - 1);
    end else if (arb_go) begin
      command_out       <= fifo_mem[win_idx][rd_ptr[win_idx]];
      command_out.valid <= 1'b1;
      grant_out         <= NUM_REQ'(1) << win_idx;
      rr_ptr            <= win_idx;
    end else begin
      command_out.valid <= 1'b0;
      grant_out         <= '0;
    end
  end

  // The status flags come straight from the registered occupancy.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      command_buffer_status_out[i].empty  = (count[i] == '0);
      command_buffer_status_out[i].alfull = (count[i] >= ALFULL_CNT);
      command_buffer_status_out[i].full   = (count[i] == FULL_CNT);
    end
  end

endmodule

// File: doc/cu_command_arbiter_rr.md
Name: cu_command_arbiter_rr

Overview:
- Shares the single CU command buffer between NUM_REQ command producers: read engines, write engines and WED fetch.
- Producers push CommandBufferLine entries with no ready signal and throttle only on BufferStatus.alfull.
- The block therefore gives each requester its own FIFO, reports per-requester BufferStatus, and drains the FIFOs round-robin into the shared command buffer under downstream alfull back-pressure.

Parameters:
NUM_REQ, 4, number of requester ports (2..8)
FIFO_DEPTH, 16, entries per requester FIFO (power of two)
ALFULL_MARGIN, 4, alfull asserts when count >= FIFO_DEPTH-ALFULL_MARGIN

Ports:
clock  in  1  clock
rst  in  1  asynchronous active-high reset
enabled_in  in  1  arbitration enable
command_in[NUM_REQ]  in  CommandBufferLine each  requester pushes; valid qualifies payload
command_buffer_status_in  in  BufferStatus  downstream command buffer status; only alfull is used
command_buffer_status_out[NUM_REQ]  out  BufferStatus each  per-requester FIFO status
command_out  out  CommandBufferLine  arbitrated command to the shared buffer
grant_out  out  NUM_REQ  one-hot index of the requester sourcing command_out, aligned with command_out.valid
overflow_error_out  out  NUM_REQ  sticky per-requester drop flag

Behaviour:
- Reset (async, rst=1):
  - All FIFOs emptied; counts 0.
  - command_out = 0; grant_out = 0; overflow_error_out = 0.
  - Status outputs: empty=1, alfull=0, full=0, all other fields 0.
  - RR pointer = NUM_REQ-1, so requester 0 has first priority.
  - Reset mid-operation discards all queued commands; nothing is replayed.
- Push:
  - command_in[i].valid=1 with FIFO i not full: the entry is written at the clock edge, regardless of enabled_in.
  - Push into a full FIFO: the entry is dropped, overflow_error_out[i] is set and stays set until reset.
- Status:
  - Driven from the registered count: empty=(count==0), full=(count==FIFO_DEPTH), alfull=(count>=FIFO_DEPTH-ALFULL_MARGIN).
  - Changes in the cycle after the causing push/pop edge.
- Arbitration:
  - Evaluated every cycle with enabled_in=1 and command_buffer_status_in.alfull=0.
  - Winner = first non-empty FIFO searching ptr+1, ptr+2, … modulo NUM_REQ.
  - The winner is popped; its head entry is registered onto command_out with valid=1 next edge, and grant_out = one-hot(winner).
  - ptr <= winner. With no winner, ptr is held.
  - At most one pop per cycle.
- Stall: enabled_in=0, or downstream alfull=1, or all FIFOs empty → no pop; next edge drives command_out.valid=0 and grant_out=0. Payload may hold a stale value.
- Latency: a push at edge N is eligible at edge N+1, so command_out.valid is seen after edge N+1 at the earliest (two-edge minimum).
- Simultaneous push and pop on the same FIFO: count unchanged. A push into a full FIFO in the same cycle as its pop is accepted (full is evaluated pre-pop is NOT used; the decision uses count minus the pop).
- Pointers: read/write pointers use log2(FIFO_DEPTH) bits and wrap naturally. Count is log2(FIFO_DEPTH)+1 bits and never exceeds FIFO_DEPTH.
- Ordering:
  - Per-requester FIFO order is preserved.
  - No ordering is guaranteed across requesters.
  - Payload, including the cmd.cu_id_x/y tags, passes through unmodified.
- Fairness: under continuous demand from all requesters, each requester gets exactly one grant per NUM_REQ consecutive grants.

Test Plan:
- Reset then requester 2 pushes 3 commands at addresses 0x1000/0x1080/0x1100 → command_out.valid on three consecutive cycles, addresses in order, grant_out=4'b0100; status_out[2].empty returns to 1.
- All 4 requesters preloaded with 2 entries, enabled_in=1 → grant sequence 0,1,2,3,0,1,2,3, one per cycle, no bubbles.
- Downstream alfull held 5 cycles mid-drain → no command_out.valid for those cycles (allowing one in flight from the prior cycle); draining resumes at the next RR index with no loss or duplication.
- Requester 1 pushes 12 entries while enabled_in=0 → status_out[1].alfull=1 after the 12th edge, full=0; push 4 more → full=1; a 17th push → dropped, overflow_error_out[1]=1 and sticky; enabling then drains exactly 16 entries.
- FIFO 0 full, simultaneous pop and push → count stays 16, no overflow flag, new entry emerges last.
- Assert rst while 3 FIFOs hold data and command_out.valid=1 → outputs zero immediately (async); after release, the first grant goes to requester 0 on a new push and no pre-reset entries appear.
